// File: rtl/console_scan_seq.sv
// Console scan sequencer: walks enabled channels row by row and requests a scan for each one.
// Optional WAIT watchdog with sticky per-channel error flags is enabled by CONSOLE_SCAN_TIMEOUT_EN.
module console_scan_seq #(
    parameter int ADDR_W      = 11,
    parameter int TOP_ADDR    = 512,
    parameter int STEP        = 8,
    parameter int CH_NUM      = 4,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           i_console_en,
    input  logic [CH_NUM-1:0]                              i_ch_en,
    input  logic                                           i_single_shot,
    input  logic                                           i_err_clr,
    input  logic                                           i_done_scan,
    output logic                                           o_start_scan,
    output logic [ADDR_W-1:0]                              om_base_addr,
    output logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] om_ch_sel,
    output logic                                           o_sweep_done,
    output logic                                           o_busy,
    output logic [CH_NUM-1:0]                              o_timeout_err
);

    localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [ADDR_W:0] STEP_X = (ADDR_W + 1)'(STEP);
    localparam logic [ADDR_W:0] TOP_X  = (ADDR_W + 1)'(TOP_ADDR);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_NEXT, ST_HOLD} state_t;

    state_t state;

    function automatic logic [CH_W-1:0] lowest_ch(input logic [CH_NUM-1:0] mask);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (mask[i]) r = CH_W'(i);
        end
        return r;
    endfunction

    // MSB flags that an enabled channel exists above cur; low bits give the nearest one.
    function automatic logic [CH_W:0] next_above(input logic [CH_NUM-1:0] mask,
                                                 input logic [CH_W-1:0]   cur);
        logic [CH_W:0] r;
        r = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) r = {1'b1, CH_W'(i)};
        end
        return r;
    endfunction

    logic [CH_W:0]   above;
    logic [CH_W-1:0] low_ch;
    logic [ADDR_W:0] addr_sum;
    logic            addr_wrap;
    logic            timeout_hit;

    assign above     = next_above(i_ch_en, om_ch_sel);
    assign low_ch    = lowest_ch(i_ch_en);
    assign addr_sum  = {1'b0, om_base_addr} + STEP_X;
    assign addr_wrap = (addr_sum >= TOP_X);

`ifdef CONSOLE_SCAN_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [CNT_W-1:0] wait_cnt;

    assign timeout_hit = (state == ST_WAIT) && !i_done_scan &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Counter restarts on every WAIT entry; a new timeout beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt      <= '0;
            o_timeout_err <= '0;
        end else begin
            if ((state == ST_WAIT) && !i_done_scan && !timeout_hit)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            o_timeout_err <= (i_err_clr ? '0 : o_timeout_err) |
                             (timeout_hit ? (CH_NUM'(1) << om_ch_sel) : '0);
        end
    end
`else
    logic unused_cfg;

    assign timeout_hit   = 1'b0;
    assign o_timeout_err = '0;
    assign unused_cfg    = &{1'b0, i_err_clr, TIMEOUT_CYC[0]};
`endif

    // Next address/channel is latched when WAIT exits, so o_sweep_done is already valid in NEXT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            o_start_scan <= 1'b0;
            om_base_addr <= '0;
            om_ch_sel    <= '0;
            o_sweep_done <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_start_scan <= 1'b0;
            o_sweep_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_console_en && (i_ch_en != '0)) begin
                        state        <= ST_WAIT;
                        om_base_addr <= '0;
                        om_ch_sel    <= low_ch;
                        o_start_scan <= 1'b1;
                        o_busy       <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (i_done_scan || timeout_hit) begin
                        state <= ST_NEXT;
                        if (above[CH_W]) begin
                            om_ch_sel <= above[CH_W-1:0];
                        end else begin
                            om_ch_sel <= low_ch;
                            if (addr_wrap) begin
                                om_base_addr <= '0;
                                o_sweep_done <= 1'b1;
                            end else begin
                                om_base_addr <= addr_sum[ADDR_W-1:0];
                            end
                        end
                    end
                end
                ST_NEXT: begin
                    if (!i_console_en || (i_ch_en == '0)) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end else if (o_sweep_done && i_single_shot) begin
                        state <= ST_HOLD;
                    end else begin
                        state        <= ST_WAIT;
                        o_start_scan <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!i_console_en) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
